// File: rtl/cla_stream_accumulator_if.sv
// Stream bus for cla_stream_accumulator: operand input channel and result output
// channel, both valid/ready. The master drives operands and consumes results;
// the slave (the accumulator) accepts operands and presents results.
interface cla_stream_accumulator_if #(
  parameter int WRAP_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_data;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_sum;
  logic [WRAP_W-1:0] out_wraps;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_wraps
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_wraps
  );
endinterface

// File: rtl/cla_stream_accumulator.sv
// cla_stream_accumulator: folds a burst of LEN 64-bit operands into a running sum
// through one 64-bit carry-look-ahead adder, counts carry-out (wrap) events in a
// saturating counter and presents the result on a valid/ready output.
// Optional build macro CLA_ACC_SUB_EN adds a 'sub' port that turns the burst into a
// running subtraction (acc - operand), where a wrap event is a borrow.
// Also contains Carry_Look_Ahead_64bit, the adder used by the accumulator.

// Three-level carry-look-ahead: 4-bit groups, 16-bit sections, 64-bit top.
module Carry_Look_Ahead_64bit (
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        Cin,
  output logic [63:0] S,
  output logic        Cout
);
  logic [63:0] g, p, c;
  logic [15:0] gg, gp, gc;
  logic [3:0]  sg, sp, sc, sec_co;

  // Carries out of each of four positions given generate/propagate and carry-in.
  function automatic logic [3:0] cla4(input logic [3:0] g4, input logic [3:0] p4,
                                      input logic ci);
    cla4[0] = g4[0] | (p4[0] & ci);
    cla4[1] = g4[1] | (p4[1] & g4[0]) | (&p4[1:0] & ci);
    cla4[2] = g4[2] | (p4[2] & g4[1]) | (&p4[2:1] & g4[0]) | (&p4[2:0] & ci);
    cla4[3] = g4[3] | (p4[3] & g4[2]) | (&p4[3:2] & g4[1]) | (&p4[3:1] & g4[0])
            | (&p4 & ci);
  endfunction

  // Generate/propagate up the tree, then carries back down to every bit.
  always_comb begin
    logic [3:0] lk;
    g = A & B;
    p = A ^ B;
    for (int i = 0; i < 16; i++) begin
      lk    = cla4(g[4*i +: 4], p[4*i +: 4], 1'b0);
      gg[i] = lk[3];
      gp[i] = &p[4*i +: 4];
    end
    for (int j = 0; j < 4; j++) begin
      lk    = cla4(gg[4*j +: 4], gp[4*j +: 4], 1'b0);
      sg[j] = lk[3];
      sp[j] = &gp[4*j +: 4];
    end
    sec_co = cla4(sg, sp, Cin);
    sc     = {sec_co[2:0], Cin};
    for (int j = 0; j < 4; j++) begin
      lk            = cla4(gg[4*j +: 4], gp[4*j +: 4], sc[j]);
      gc[4*j +: 4]  = {lk[2:0], sc[j]};
    end
    for (int i = 0; i < 16; i++) begin
      lk           = cla4(g[4*i +: 4], p[4*i +: 4], gc[i]);
      c[4*i +: 4]  = {lk[2:0], gc[i]};
    end
    S    = p ^ c;
    Cout = sec_co[3];
  end
endmodule

module cla_stream_accumulator #(
  parameter int CNT_W  = 16,
  parameter int WRAP_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     len,
`ifdef CLA_ACC_SUB_EN
  input  logic                 sub,
`endif
  output logic                 busy,
  cla_stream_accumulator_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [63:0]       acc_q, acc_d;
  logic [63:0]       sum_q, sum_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;
  logic [WRAP_W-1:0] owr_q, owr_d;
  logic              sub_q, sub_d;

  logic        beat;
  logic [63:0] add_b, add_s;
  logic        add_ci, add_co, wrap_evt;

  // Wrap counter sticks at all-ones instead of rolling over.
  function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
    sat_inc = (&v) ? v : v + WRAP_ONE;
  endfunction

  assign bus.in_ready  = (state_q == S_ACCUM);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_wraps = owr_q;
  assign busy          = (state_q != S_IDLE);
  assign beat          = bus.in_valid && (state_q == S_ACCUM);

`ifdef CLA_ACC_SUB_EN
  // Subtract as acc + ~x + 1; a missing carry-out means the subtraction borrowed.
  assign add_b    = sub_q ? ~bus.in_data : bus.in_data;
  assign add_ci   = sub_q;
  assign wrap_evt = sub_q ? ~add_co : add_co;
`else
  assign add_b    = bus.in_data;
  assign add_ci   = 1'b0;
  assign wrap_evt = add_co;
  assign sub_d    = 1'b0;
`endif

  Carry_Look_Ahead_64bit u_cla (
    .A    (acc_q),
    .B    (add_b),
    .Cin  (add_ci),
    .S    (add_s),
    .Cout (add_co)
  );

  // Burst sequencing: arm on start, fold one operand per beat, hold result until taken.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    rem_d   = rem_q;
    wraps_d = wraps_q;
    owr_d   = owr_q;
`ifdef CLA_ACC_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          wraps_d = '0;
`ifdef CLA_ACC_SUB_EN
          sub_d   = sub;
`endif
          if (len != '0) begin
            rem_d   = len;
            state_d = S_ACCUM;
          end else begin
            sum_d   = '0;
            owr_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_ACCUM: begin
        if (beat) begin
          acc_d = add_s;
          rem_d = rem_q - CNT_ONE;
          if (wrap_evt) wraps_d = sat_inc(wraps_q);
          if (rem_q == CNT_ONE) begin
            sum_d   = add_s;
            owr_d   = wraps_d;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      sum_q   <= '0;
      rem_q   <= '0;
      wraps_q <= '0;
      owr_q   <= '0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      rem_q   <= rem_d;
      wraps_q <= wraps_d;
      owr_q   <= owr_d;
      sub_q   <= sub_d;
    end
  end
endmodule
